// File: rtl/exu_arbiter.sv
// exu_arbiter: shares one single-cycle exu between EX (r0) and branch/addr-compare (r1); build option EXU_ARB_RR_EN.
// Latency: accept in cycle T -> registered result in rsp_* in cycle T+1; one op per cycle when rsp_ready is held.
// Backpressure: a full, unpopped response slot deasserts both readys and zeroes the exu_* outputs.
module exu_arbiter #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          r0_valid,
    output logic          r0_ready,
    input  logic [DW-1:0] r0_a,
    input  logic [DW-1:0] r0_b,
    input  logic [2:0]    r0_alu_op,
    input  logic          r0_sub,
    input  logic          r0_slt_s,
    input  logic          r0_slt_u,
    input  logic          r1_valid,
    output logic          r1_ready,
    input  logic [DW-1:0] r1_a,
    input  logic [DW-1:0] r1_b,
    input  logic [2:0]    r1_alu_op,
    input  logic          r1_sub,
    input  logic          r1_slt_s,
    input  logic          r1_slt_u,
    output logic [DW-1:0] exu_a,
    output logic [DW-1:0] exu_b,
    output logic [2:0]    exu_alu_op,
    output logic          exu_sub,
    output logic          exu_slt_s,
    output logic          exu_slt_u,
    input  logic [DW-1:0] exu_res,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_res
);

    logic          r_rsp_valid;
    logic          r_rsp_id;
    logic [DW-1:0] r_rsp_res;

    logic w_free;
    logic w_gnt;
    logic w_acc;
    logic w_prio;

    // The slot can take a new result when it is empty or being popped this cycle.
    assign w_free = !r_rsp_valid || rsp_ready;

    // Winner: the lone valid requester, or the priority pointer when both are valid.
    always_comb begin
        w_gnt = 1'b0;
        if (r0_valid && r1_valid) begin
            w_gnt = w_prio;
        end else if (r1_valid) begin
            w_gnt = 1'b1;
        end
    end

    // rst_n gating keeps readys (and hence exu_*) low throughout reset,
    // since the cleared slot would otherwise look free.
    assign w_acc    = rst_n && w_free && (r0_valid || r1_valid);
    assign r0_ready = w_acc && !w_gnt;
    assign r1_ready = w_acc &&  w_gnt;

    // Steer the winner's fields to the exu only on an accept; idle cycles drive zeros.
    always_comb begin
        exu_a      = '0;
        exu_b      = '0;
        exu_alu_op = 3'd0;
        exu_sub    = 1'b0;
        exu_slt_s  = 1'b0;
        exu_slt_u  = 1'b0;
        if (w_acc) begin
            if (w_gnt) begin
                exu_a      = r1_a;
                exu_b      = r1_b;
                exu_alu_op = r1_alu_op;
                exu_sub    = r1_sub;
                exu_slt_s  = r1_slt_s;
                exu_slt_u  = r1_slt_u;
            end else begin
                exu_a      = r0_a;
                exu_b      = r0_b;
                exu_alu_op = r0_alu_op;
                exu_sub    = r0_sub;
                exu_slt_s  = r0_slt_s;
                exu_slt_u  = r0_slt_u;
            end
        end
    end

    // One-entry response slot: load on accept (covers pop+accept), clear on a bare pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_res   <= '0;
        end else if (w_acc) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= w_gnt;
            r_rsp_res   <= exu_res;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

`ifdef EXU_ARB_RR_EN
    logic r_prio;

    // Round-robin: after each accept the other requester wins the next conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (w_acc) begin
            r_prio <= ~w_gnt;
        end
    end

    assign w_prio = r_prio;
`else
    // Fixed priority: r0 always wins a conflict.
    assign w_prio = 1'b0;
`endif

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_res   = r_rsp_res;

endmodule

// File: tb/tb_exu_arbiter.sv
module tb_exu_arbiter;

    localparam int DW = 64;

    logic          clk;
    logic          rst_n;
    logic          r0_valid, r1_valid;
    logic          r0_ready, r1_ready;
    logic [DW-1:0] r0_a, r0_b, r1_a, r1_b;
    logic [2:0]    r0_alu_op, r1_alu_op;
    logic          r0_sub, r0_slt_s, r0_slt_u;
    logic          r1_sub, r1_slt_s, r1_slt_u;
    logic [DW-1:0] exu_a, exu_b, exu_res;
    logic [2:0]    exu_alu_op;
    logic          exu_sub, exu_slt_s, exu_slt_u;
    logic          rsp_valid, rsp_ready, rsp_id;
    logic [DW-1:0] rsp_res;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference exu used both as the DUT's combinational datapath and by the model.
    function automatic logic [DW-1:0] exu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [2:0] op, input logic sub,
                                            input logic ss, input logic su);
        logic [DW-1:0] r;
        if (ss)       r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
        else if (su)  r = (a < b) ? 64'd1 : 64'd0;
        else begin
            case (op)
                3'd0:    r = sub ? (a - b) : (a + b);
                3'd1:    r = a & b;
                3'd2:    r = a | b;
                3'd3:    r = a ^ b;
                default: r = a;
            endcase
        end
        return r;
    endfunction

    assign exu_res = exu_f(exu_a, exu_b, exu_alu_op, exu_sub, exu_slt_s, exu_slt_u);

    exu_arbiter #(.DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
        .r0_alu_op(r0_alu_op), .r0_sub(r0_sub), .r0_slt_s(r0_slt_s), .r0_slt_u(r0_slt_u),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
        .r1_alu_op(r1_alu_op), .r1_sub(r1_sub), .r1_slt_s(r1_slt_s), .r1_slt_u(r1_slt_u),
        .exu_a(exu_a), .exu_b(exu_b), .exu_alu_op(exu_alu_op),
        .exu_sub(exu_sub), .exu_slt_s(exu_slt_s), .exu_slt_u(exu_slt_u),
        .exu_res(exu_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_res(rsp_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: slot contents and conflict priority.
    logic          m_valid, m_id, m_prio;
    logic [DW-1:0] m_res;
    logic          hs0, hs1;

    initial begin
        m_valid = 1'b0; m_id = 1'b0; m_prio = 1'b0; m_res = '0;
        hs0 = 1'b0; hs1 = 1'b0;
    end

    // Compare every cycle on the falling edge, then advance the model to the next rising edge.
    always @(negedge clk) begin
        logic free, any, acc, win;
        logic [DW-1:0] ea, eb;
        logic [2:0] eop;
        logic es, ess, esu;
        hs0 = r0_valid && r0_ready;
        hs1 = r1_valid && r1_ready;
        if (!rst_n) begin
            m_valid = 1'b0; m_id = 1'b0; m_prio = 1'b0; m_res = '0;
            chk("rst.rsp_valid", {63'd0, rsp_valid}, 64'd0);
            chk("rst.rsp_id",    {63'd0, rsp_id},    64'd0);
            chk("rst.rsp_res",   rsp_res,            64'd0);
            chk("rst.r0_ready",  {63'd0, r0_ready},  64'd0);
            chk("rst.r1_ready",  {63'd0, r1_ready},  64'd0);
            chk("rst.exu_a",     exu_a,              64'd0);
        end else begin
            free = !m_valid || rsp_ready;
            any  = r0_valid || r1_valid;
            acc  = free && any;
            win  = (r0_valid && r1_valid) ? m_prio : r1_valid;
            ea = '0; eb = '0; eop = 3'd0; es = 1'b0; ess = 1'b0; esu = 1'b0;
            if (acc) begin
                ea  = win ? r1_a : r0_a;
                eb  = win ? r1_b : r0_b;
                eop = win ? r1_alu_op : r0_alu_op;
                es  = win ? r1_sub : r0_sub;
                ess = win ? r1_slt_s : r0_slt_s;
                esu = win ? r1_slt_u : r0_slt_u;
            end
            chk("cyc.rsp_valid", {63'd0, rsp_valid}, {63'd0, m_valid});
            chk("cyc.rsp_id",    {63'd0, rsp_id},    {63'd0, m_id});
            chk("cyc.rsp_res",   rsp_res,            m_res);
            chk("cyc.r0_ready",  {63'd0, r0_ready},  {63'd0, acc && !win});
            chk("cyc.r1_ready",  {63'd0, r1_ready},  {63'd0, acc && win});
            chk("cyc.exu_a",     exu_a,              ea);
            chk("cyc.exu_b",     exu_b,              eb);
            chk("cyc.exu_ctl",   {58'd0, exu_alu_op, exu_sub, exu_slt_s, exu_slt_u},
                                 {58'd0, eop, es, ess, esu});
            if (acc) begin
                m_valid = 1'b1;
                m_id    = win;
                m_res   = exu_f(ea, eb, eop, es, ess, esu);
`ifdef EXU_ARB_RR_EN
                m_prio  = ~win;
`endif
            end else if (rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic set_req(input int n, input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [2:0] op, input logic sub, input logic ss, input logic su);
        if (n == 0) begin
            r0_valid = v; r0_a = a; r0_b = b; r0_alu_op = op; r0_sub = sub; r0_slt_s = ss; r0_slt_u = su;
        end else begin
            r1_valid = v; r1_a = a; r1_b = b; r1_alu_op = op; r1_sub = sub; r1_slt_s = ss; r1_slt_u = su;
        end
    endtask

    task automatic rand_req(input int n);
        int f;
        f = $urandom_range(0, 3);
        set_req(n, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom_range(0, 4)),
                1'($urandom_range(0, 1)), f == 2, f == 3);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic ids [4];

    initial begin
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        set_req(0, 1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0);
        set_req(1, 1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();

        // Reset release with r0 add 5+3 ready to go
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 64'd5, 64'd3, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("add.r0_ready", {63'd0, r0_ready}, 64'd1);
        chk("add.exu_a", exu_a, 64'd5);
        tick();
        r0_valid = 1'b0;
        @(negedge clk);
        chk("add.rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("add.rsp_id", {63'd0, rsp_id}, 64'd0);
        chk("add.rsp_res", rsp_res, 64'd8);

        // Signed then unsigned slt via r1
        tick();
        set_req(1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("slts.r1_ready", {63'd0, r1_ready}, 64'd1);
        tick();
        set_req(1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("slts.rsp_res", rsp_res, 64'd1);
        chk("slts.rsp_id", {63'd0, rsp_id}, 64'd1);
        tick();
        r1_valid = 1'b0;
        @(negedge clk);
        chk("sltu.rsp_res", rsp_res, 64'd0);

        // Contention: both valid for several cycles
        tick();
        set_req(0, 1'b1, 64'd10, 64'd1, 3'd0, 1'b0, 1'b0, 1'b0);
        set_req(1, 1'b1, 64'd20, 64'd2, 3'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            ids[i] = rsp_id;
        end
        for (int i = 0; i < 4; i++) begin
`ifdef EXU_ARB_RR_EN
            chk($sformatf("cont.id%0d", i), {63'd0, ids[i]}, 64'(i % 2));
`else
            chk($sformatf("cont.id%0d", i), {63'd0, ids[i]}, 64'd0);
`endif
        end
`ifndef EXU_ARB_RR_EN
        tick();
        r0_valid = 1'b0;
        @(negedge clk);
        chk("starve.r1_ready", {63'd0, r1_ready}, 64'd1);
`endif
        tick();
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        tick();

        // Backpressure: result 0xF0 ^ 0xFF, then stall for three cycles
        set_req(0, 1'b1, 64'hF0, 64'hFF, 3'd3, 1'b0, 1'b0, 1'b0);
        tick();
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 64'd7, 64'd2, 3'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall.r0_ready", {63'd0, r0_ready}, 64'd0);
            chk("stall.exu_a", exu_a, 64'd0);
            chk("stall.rsp_res", rsp_res, 64'h0F);
            chk("stall.rsp_valid", {63'd0, rsp_valid}, 64'd1);
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("popacc.r0_ready", {63'd0, r0_ready}, 64'd1);
        tick();
        r0_valid = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("popacc.rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("popacc.rsp_res", rsp_res, 64'd5);

        // Reset mid-stall, then contention right after release
        tick();
        set_req(0, 1'b1, 64'd1, 64'd1, 3'd0, 1'b0, 1'b0, 1'b0);
        set_req(1, 1'b1, 64'd2, 64'd2, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst.rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("arst.rsp_res", rsp_res, 64'd0);
        chk("arst.r0_ready", {63'd0, r0_ready}, 64'd0);
        chk("arst.r1_ready", {63'd0, r1_ready}, 64'd0);
        rsp_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst.r0_ready", {63'd0, r0_ready}, 64'd1);
        chk("postrst.r1_ready", {63'd0, r1_ready}, 64'd0);

        // Randomised traffic obeying the hold-until-ready rule
        repeat (3000) begin
            tick();
            if (!r0_valid || hs0) begin
                if ($urandom_range(0, 9) < 7) rand_req(0);
                else r0_valid = 1'b0;
            end
            if (!r1_valid || hs1) begin
                if ($urandom_range(0, 9) < 7) rand_req(1);
                else r1_valid = 1'b0;
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
        end
        tick();
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
